// File: rtl/subband_synthesis_combiner.sv
// subband_synthesis_combiner: gain-weighted sum of NBANDS band samples via one time-multiplexed MAC, rounded and saturated
module subband_synthesis_combiner #(
  parameter int NBANDS    = 16,
  parameter int IN_W      = 33,
  parameter int IN_FRAC   = 32,
  parameter int GAIN_W    = 16,
  parameter int GAIN_FRAC = 14,
  parameter int OUT_W     = 13,
  parameter int OUT_FRAC  = 12
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clk_enable,
  input  logic [NBANDS*IN_W-1:0]      band_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        gain_we,
  input  logic [$clog2(NBANDS)-1:0]   gain_addr,
  input  logic [GAIN_W-1:0]           gain_data,
  output logic                        gain_ready,
  output logic [OUT_W-1:0]            filter_out,
  output logic                        out_valid,
  output logic                        sat_flag
);
  localparam int AW    = $clog2(NBANDS);
  localparam int PW    = IN_W + GAIN_W;
  localparam int ACC_W = PW + AW;
  localparam int S     = IN_FRAC + GAIN_FRAC - OUT_FRAC;
  localparam int RW    = ACC_W - S;
  localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (S - 1);
  localparam logic signed [RW-1:0] MAXV = RW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [RW-1:0] MINV = RW'(-(1 << (OUT_W - 1)));
  typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;
  state_t state, state_nx;
  logic [NBANDS*IN_W-1:0] hold;
  logic signed [GAIN_W-1:0] gain [NBANDS];
  logic signed [ACC_W-1:0] acc, rsum;
  logic [AW-1:0] idx;
  logic signed [IN_W-1:0] band_sel;
  logic signed [PW-1:0] prod;
  logic signed [RW-1:0] r;
  logic hi, lo;
  logic [OUT_W-1:0] clip;
  assign in_ready   = state == IDLE;
  assign gain_ready = state == IDLE;
  assign band_sel   = hold[idx*IN_W +: IN_W];
  assign prod       = PW'(band_sel) * PW'(gain[idx]);
  assign rsum       = acc + HALF;
  assign r          = rsum[ACC_W-1:S];
  assign hi         = r > MAXV;
  assign lo         = r < MINV;
  assign clip       = hi ? MAXV[OUT_W-1:0] : lo ? MINV[OUT_W-1:0] : r[OUT_W-1:0];
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (in_valid ? MAC : IDLE)
             : state == MAC  ? (idx == AW'(NBANDS - 1) ? ROUND : MAC)
             : IDLE;
  end
  // gain writes land before a same-edge transfer's first MAC, so a new sample sees them
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold       <= '0;
      acc        <= '0;
      idx        <= '0;
      filter_out <= '0;
      out_valid  <= 1'b0;
      sat_flag   <= 1'b0;
      for (int i = 0; i < NBANDS; i++) gain[i] <= GAIN_W'(1 << GAIN_FRAC);
    end else if (clk_enable) begin
      state     <= state_nx;
      out_valid <= state == ROUND;
      sat_flag  <= state == ROUND && (hi || lo);
      if (gain_we && gain_ready) gain[gain_addr] <= gain_data;
      if (state == IDLE && in_valid) begin
        hold <= band_in;
        acc  <= '0;
        idx  <= '0;
      end
      if (state == MAC) begin
        acc <= acc + ACC_W'(prod);
        idx <= idx + AW'(1);
      end
      if (state == ROUND) filter_out <= clip;
    end
  end
endmodule
